// File: rtl/nios_chave_poller.sv
// Periodic Avalon-MM poller for a 4-bit switch bank, with change pulse and sticky irq.
// Define NIOS_CHAVE_POLLER_DEBOUNCE_EN to require DB_COUNT consecutive equal samples before accepting a value.
module nios_chave_poller #(
    parameter int unsigned POLL_DIV = 50000,
    parameter int unsigned DB_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [3:0]  value,
    output logic        changed,
    output logic        irq,
    input  logic        irq_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [23:0] PRESCALE_LAST = 24'(POLL_DIV - 1);

    state_t      state_q, state_d;
    logic [23:0] prescaler_q, prescaler_d;
    logic [3:0]  value_q, value_d;
    logic        changed_q, changed_d;
    logic        irq_q, irq_d;
    logic [3:0]  sample;

    // Only the low nibble carries switch state; the rest of the word is don't-care.
    logic        unused_readdata_hi;
    assign unused_readdata_hi = ^avm_readdata[31:4];
    assign sample             = avm_readdata[3:0];

`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
    localparam logic [3:0] DB_TARGET = 4'(DB_COUNT);
    logic [3:0] cand_q, cand_d;
    logic [3:0] db_cnt_q, db_cnt_d;
`endif

    // NOTE: state flops use non-blocking assignments with an asynchronous clear, so every
    // register reads its pre-edge value no matter the order the simulator evaluates them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            value_q     <= 4'h0;
            changed_q   <= 1'b0;
            irq_q       <= 1'b0;
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
            cand_q      <= 4'h0;
            db_cnt_q    <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            value_q     <= value_d;
            changed_q   <= changed_d;
            irq_q       <= irq_d;
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
            cand_q      <= cand_d;
            db_cnt_q    <= db_cnt_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        value_d     = value_q;
        changed_d   = 1'b0;
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
        cand_d      = cand_q;
        db_cnt_d    = db_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    prescaler_d = '0;
                end else if (prescaler_q == PRESCALE_LAST) begin
                    prescaler_d = '0;
                    state_d     = S_READ;
                end else begin
                    prescaler_d = prescaler_q + 24'd1;
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                state_d = S_IDLE;
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
                if (sample == cand_q) begin
                    if (db_cnt_q < DB_TARGET) db_cnt_d = db_cnt_q + 4'd1;
                end else begin
                    cand_d   = sample;
                    db_cnt_d = 4'd1;
                end
                if (db_cnt_d == DB_TARGET && cand_d != value_q) begin
                    value_d   = cand_d;
                    changed_d = 1'b1;
                end
`else
                if (sample != value_q) begin
                    value_d   = sample;
                    changed_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Set takes priority so an ack racing a fresh change cannot lose the event.
        if (changed_q)    irq_d = 1'b1;
        else if (irq_ack) irq_d = 1'b0;
        else              irq_d = irq_q;
    end

    always_comb begin
        avm_address = 2'b00;
        avm_read    = (state_q == S_READ);
        value       = value_q;
        changed     = changed_q;
        irq         = irq_q;
    end

endmodule

// File: tb/tb_nios_chave_poller.sv
// Self-checking bench for nios_chave_poller: directed vector table, multi-cycle corner
// sequences, and a randomized run against a timeline/history reference model.
module tb_nios_chave_poller;

    localparam int P  = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        irq_ack;
    logic [31:0] avm_readdata;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [3:0]  value;
    logic        changed;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nios_chave_poller #(.POLL_DIV(P), .DB_COUNT(DB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .value        (value),
        .changed      (changed),
        .irq          (irq),
        .irq_ack      (irq_ack)
    );

    typedef struct {
        logic [31:0] rd;
        logic        ack;
        logic [3:0]  exp_value;
        logic        exp_changed;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, where inputs are also driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read(output int waited);
        waited = 0;
        while (avm_read !== 1'b1 && waited < 3 * P + 10) begin
            tick();
            waited++;
        end
        check("read_seen", avm_read, 1);
    endtask

    // Ends in the cycle right after CAPTURE; readdata is only valid during CAPTURE.
    task automatic do_poll(input logic [31:0] rd);
        int w;
        wait_read(w);
        avm_readdata = ~rd;
        tick();
        avm_readdata = rd;
        tick();
        avm_readdata = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avm_read"}, avm_read, 0);
        check({tag, "_avm_address"}, avm_address, 0);
        check({tag, "_value"}, value, 0);
        check({tag, "_changed"}, changed, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [3:0]  old_v;
        logic [31:0] rd;
        logic [31:0] r;
        logic [3:0]  mv, sw, s;
        logic        mch, mirq, nch, cap, all_eq;
        logic [3:0]  hist [$];

`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
        tbl[0] = '{32'hFFFF_FFF0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0005, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0005, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[3] = '{32'h0000_0003, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[4] = '{32'h0000_0003, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_0003, 1'b1, 4'h3, 1'b1, 1'b1};
        tbl[6] = '{32'h0000_0003, 1'b1, 4'h3, 1'b0, 1'b0};
        tbl[7] = '{32'h0000_0005, 1'b0, 4'h3, 1'b0, 1'b0};
`else
        tbl[0] = '{32'hFFFF_FFF0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0005, 1'b0, 4'h5, 1'b1, 1'b1};
        tbl[2] = '{32'hABCD_1235, 1'b0, 4'h5, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_000C, 1'b1, 4'hC, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_000C, 1'b1, 4'hC, 1'b0, 1'b0};
        tbl[5] = '{32'h1234_567F, 1'b0, 4'hF, 1'b1, 1'b1};
        tbl[6] = '{32'h0000_0000, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[7] = '{32'h0000_0000, 1'b1, 4'h0, 1'b0, 1'b0};
`endif

        // Reset state
        reset_n      = 1'b0;
        enable       = 1'b1;
        irq_ack      = 1'b0;
        avm_readdata = 32'h0;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Poll period: reads at cycles P, 2P+2, 3P+4 after release
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("poll_period", avm_read, (c >= P && (c - P) % (P + 2) == 0) ? 1 : 0);
            check("address_zero", avm_address, 0);
        end

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            do_poll(tbl[i].rd);
            check($sformatf("vec%0d_value", i), value, tbl[i].exp_value);
            check($sformatf("vec%0d_changed", i), changed, tbl[i].exp_changed);
            irq_ack = tbl[i].ack;
            tick();
            irq_ack = 1'b0;
            check($sformatf("vec%0d_irq", i), irq, tbl[i].exp_irq);
            check($sformatf("vec%0d_changed_done", i), changed, 0);
        end

        // Dropping enable during a transaction lets the sample complete, then idles
        old_v = value;
        rd    = {28'h0, ~old_v};
        wait_read(w);
        enable = 1'b0;
        tick();
        avm_readdata = rd;
        tick();
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
        check("disable_value", value, old_v);
`else
        check("disable_value", value, rd[3:0]);
        check("disable_changed", changed, 1);
`endif
        for (int c = 0; c < 12; c++) begin
            tick();
            check("disabled_no_read", avm_read, 0);
        end
        enable = 1'b1;
        wait_read(w);
        check("reenable_latency", w, P);

        // Reset during CAPTURE discards the sample
        tick();
        avm_readdata = 32'h0000_0009;
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_read(w);
        check("post_reset_latency", w, P);
        check("post_reset_value", value, 0);

        // Randomized run against the reference model
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        mv   = 4'h0;
        mch  = 1'b0;
        mirq = 1'b0;
        sw   = 4'h0;
        hist = {};
        for (int k = 0; k < 600; k++) begin
            check("rnd_read", avm_read, (k >= P && (k - P) % (P + 2) == 0) ? 1 : 0);
            check("rnd_value", value, mv);
            check("rnd_changed", changed, mch);
            check("rnd_irq", irq, mirq);
            cap = (k >= P + 1) && ((k - P - 1) % (P + 2) == 0);
            if (cap && $urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
            r = $urandom;
            avm_readdata = {r[31:4], cap ? sw : r[3:0]};
            irq_ack = ($urandom_range(0, 5) == 0);
            nch = 1'b0;
            if (cap) begin
                s = sw;
`ifdef NIOS_CHAVE_POLLER_DEBOUNCE_EN
                hist.push_back(s);
                if (hist.size() > DB) void'(hist.pop_front());
                all_eq = (hist.size() == DB);
                foreach (hist[i]) if (hist[i] != s) all_eq = 1'b0;
                if (all_eq && s != mv) begin
                    mv  = s;
                    nch = 1'b1;
                end
`else
                if (s != mv) begin
                    mv  = s;
                    nch = 1'b1;
                end
`endif
            end
            mirq = mch | (mirq & ~irq_ack);
            mch  = nch;
            tick();
        end
        irq_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_chave_poller.md
NIOS_CHAVE_POLLER -- requirements
Module: nios_chave_poller

Interface
REQ-001 SHALL have parameter POLL_DIV, default 50000, clk cycles between poll reads (legal range 4..2^24-1).
REQ-002 SHALL have parameter DB_COUNT, default 3, consecutive equal samples required when debounce is compiled in (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  polling enable; 0 = prescaler held at 0, no new reads.
REQ-006 SHALL have port avm_address  output  2  Avalon-MM read address; constant 2'b00.
REQ-007 SHALL have port avm_read  output  1  Avalon-MM read strobe, one-cycle pulse per poll.
REQ-008 SHALL have port avm_readdata  input  32  slave read data, fixed read latency 1; only bits [3:0] used.
REQ-009 SHALL have port value  output  4  last accepted switch value.
REQ-010 SHALL have port changed  output  1  one-cycle pulse when value updates to a different code.
REQ-011 SHALL have port irq  output  1  sticky level interrupt, set on change.
REQ-012 SHALL have port irq_ack  input  1  clears irq.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> CAPTURE -> IDLE.
REQ-014 IDLE SHALL increment prescaler while enable=1, and SHALL go to READ when prescaler = POLL_DIV-1, resetting prescaler to 0.
REQ-015 READ SHALL assert avm_read for exactly one cycle, then go to CAPTURE unconditionally.
REQ-016 CAPTURE SHALL sample avm_readdata[3:0] (the cycle after avm_read), then return to IDLE; bits [31:4] ignored.
REQ-017 Poll period SHALL be exactly POLL_DIV+2 cycles between avm_read pulses with enable held at 1.
REQ-018 enable deasserted in READ or CAPTURE SHALL NOT abort the transaction; the sample completes, then IDLE holds.
REQ-019 Without debounce, a captured sample differing from value SHALL load value and pulse changed on the cycle after CAPTURE.
REQ-020 A sample equal to value SHALL produce no changed pulse and leave irq unchanged.
REQ-021 irq SHALL be set on the changed pulse, held until irq_ack=1, and cleared the next cycle.
REQ-022 Simultaneous changed and irq_ack SHALL leave irq=1 (set wins).
REQ-023 avm_address SHALL be 2'b00 at all times, including during reset.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=IDLE, prescaler=0, avm_read=0, value=4'h0, changed=0, irq=0, and debounce counter and candidate to 0.
REQ-025 Reset asserted mid-transaction SHALL discard the in-flight sample; the first read after release occurs POLL_DIV cycles after the first enabled cycle.

Configuration
REQ-026 Macro NIOS_CHAVE_POLLER_DEBOUNCE_EN, when defined, SHALL include a 4-bit candidate register and a 4-bit stability counter.
REQ-027 With debounce compiled in, a sample equal to candidate SHALL increment the counter (saturating at DB_COUNT); a sample differing from candidate SHALL load candidate and set the counter to 1.
REQ-028 With debounce compiled in, value SHALL load candidate and changed SHALL pulse only when the counter reaches DB_COUNT and candidate != value.
REQ-029 Without the macro, REQ-019 behaviour applies and no debounce registers exist.

Verification
REQ-030 Scenario: POLL_DIV=4, enable=1 from reset -> avm_read pulses on cycles 4, 10, 16 (period 6); avm_address=0 always.
REQ-031 Scenario: readdata 0x0000_0005 after the 1st read, no debounce -> value=4'h5, changed pulses 1 cycle, irq=1 until irq_ack.
REQ-032 Scenario: readdata 0xFFFF_FFF0 -> value=4'h0, no changed pulse (upper bits ignored).
REQ-033 Scenario: DEBOUNCE_EN, DB_COUNT=3, samples 5,5,3,3,3 -> value=4'h3 after the 5th capture only, exactly one changed pulse.
REQ-034 Scenario: changed and irq_ack in the same cycle -> irq remains 1; a later irq_ack alone clears it.
REQ-035 Scenario: reset_n low during CAPTURE with readdata=0x9 -> all outputs 0 immediately; value stays 0 after release.
